alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_INIT, default 1, SHALL be the round-robin last-grant pointer value loaded at reset (1 means requester 0 wins the first tie).
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port req0_valid  input  1  SHALL flag that requester 0 presents an operation.
REQ-005 Port req0_ready  output  1  SHALL flag that requester 0's operation is accepted this cycle.
REQ-006 Port req0_srca, req0_srcb  input  32 each  SHALL be requester 0's operands.
REQ-007 Port req0_alucontrol  input  3  SHALL be requester 0's ALU opcode.
REQ-008 Ports req1_valid, req1_ready, req1_srca, req1_srcb, req1_alucontrol SHALL mirror REQ-004..007 for requester 1.
REQ-009 Port rsp_valid  output  1  SHALL flag a held result.
REQ-010 Port rsp_ready  input  1  SHALL flag that the consumer takes the result this cycle.
REQ-011 Port rsp_id  output  1  SHALL identify the requester owning the result.
REQ-012 Port rsp_aluout  output  32  SHALL be the ALU result; port rsp_zero  output  1  SHALL be the ALU zero flag.

Function
REQ-013 Opcodes SHALL be 000 AND, 001 OR, 010 ADD, 110 SUB, 101 MUL (low 32 bits), 111 unsigned set-less-than (1/0); any other code SHALL give result 0.
REQ-014 rsp_zero SHALL be 1 exactly when rsp_aluout is 0.
REQ-015 FSM SHALL have states IDLE and HOLD; reset enters IDLE.
REQ-016 Accept-enable SHALL be (state==IDLE) or (state==HOLD and rsp_ready).
REQ-017 With accept-enable and only one reqN_valid high, that requester SHALL be granted.
REQ-018 With accept-enable and both valid, the requester not equal to the last-grant pointer SHALL be granted.
REQ-019 reqN_ready SHALL be combinational, high only for the granted requester while accept-enable holds; never both high.
REQ-020 On acceptance, operands, opcode and id SHALL be registered, the pointer SHALL update to the granted id, and state SHALL be HOLD next cycle.
REQ-021 Latency SHALL be one cycle: rsp_valid high the cycle after acceptance, result computed combinationally from the registered operands.
REQ-022 In HOLD with rsp_ready low, rsp_valid, rsp_id, rsp_aluout and rsp_zero SHALL stay stable and both reqN_ready SHALL be low.
REQ-023 In HOLD with rsp_ready high and no request, state SHALL return to IDLE and rsp_valid SHALL drop next cycle.
REQ-024 In HOLD with rsp_ready high and a request present, the new operation SHALL be accepted the same cycle (back-to-back, one result per cycle).
REQ-025 Requests whose valid drops before acceptance SHALL be ignored without error.

Reset
REQ-026 Assertion of reset_n low SHALL immediately force state IDLE, rsp_valid 0, rsp_id 0, operand/opcode registers 0 (so rsp_aluout 0, rsp_zero 1), and pointer RR_INIT.
REQ-027 Reset during HOLD SHALL discard the held result; it SHALL never be presented.

Configuration
REQ-028 With macro ALU_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win ties and the pointer SHALL not be implemented.
REQ-029 Without ALU_ARB_FIXED_PRIO_EN, the round-robin of REQ-018 SHALL apply.

Structure
REQ-030 Package alu_arb_pkg SHALL hold the opcode constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_MUL, ALU_SLT) and typedef alu_req_t {srca, srcb, alucontrol}.
REQ-031 The existing alu module SHALL be instanced once as the sole sub-module, fed from the registered operands.

Verification
REQ-032 req0: srca 5, srcb 3, op 010; rsp_ready 1 -> req0_ready same cycle; next cycle rsp_valid 1, id 0, aluout 8, zero 0.
REQ-033 Both valid every cycle, rsp_ready 1, after reset -> grants alternate 0,1,0,1; under ALU_ARB_FIXED_PRIO_EN all grants go to 0.
REQ-034 req1: 7 SUB 7 with rsp_ready 0 for 3 cycles -> aluout 0, zero 1, id 1 stable; req0 held valid gets no ready until rsp_ready rises, then is accepted that cycle.
REQ-035 Ops 0x10000 MUL 0x10000 -> 0; 2 SLT 3 -> 1; 3 SLT 2 -> 0; opcode 011 -> aluout 0, zero 1.
REQ-036 reset_n low while HOLD with rsp_ready 0 -> rsp_valid 0 at once; after release, first tie grants requester 0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared opcode constants, request record and FSM state type for the
// two-requester ALU arbiter.
package alu_arb_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [2:0]  alucontrol;
  } alu_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; unknown opcodes yield 0, SLT is unsigned.
module alu
  import alu_arb_pkg::*;
(
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic [2:0]  alucontrol,
  output logic [31:0] aluout,
  output logic        zero
);

  always_comb begin
    aluout = '0;
    case (alucontrol)
      ALU_AND: aluout = srca & srcb;
      ALU_OR:  aluout = srca | srcb;
      ALU_ADD: aluout = srca + srcb;
      ALU_SUB: aluout = srca - srcb;
      ALU_MUL: aluout = srca * srcb;
      ALU_SLT: aluout = {31'b0, (srca < srcb)};
      default: aluout = '0;
    endcase
  end

  assign zero = (aluout == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single ALU with a one-entry result hold.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter bit RR_INIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_srca,
  input  logic [31:0] req0_srcb,
  input  logic [2:0]  req0_alucontrol,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_srca,
  input  logic [31:0] req1_srcb,
  input  logic [2:0]  req1_alucontrol,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_aluout,
  output logic        rsp_zero
);

  arb_state_e state_q;
  alu_req_t   op_q;
  alu_req_t   req_d;
  logic       rsp_valid_q;
  logic       rsp_id_q;
  logic       accept_en;
  logic       grant_id;
  logic       accept;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic       ptr_q;
`endif

  assign accept_en = (state_q == ST_IDLE) || rsp_ready;

  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_id = 1'b0;
`else
      // Tie goes to whichever requester was not granted last.
      grant_id = ~ptr_q;
`endif
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign accept     = accept_en && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept &&  grant_id;

  always_comb begin
    req_d = grant_id ? '{srca: req1_srca, srcb: req1_srcb, alucontrol: req1_alucontrol}
                     : '{srca: req0_srca, srcb: req0_srcb, alucontrol: req0_alucontrol};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q       <= RR_INIT;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q     <= ST_HOLD;
            rsp_valid_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (rsp_ready && !accept) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
      if (accept) begin
        op_q     <= req_d;
        rsp_id_q <= grant_id;
`ifndef ALU_ARB_FIXED_PRIO_EN
        ptr_q    <= grant_id;
`endif
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;

  alu u_alu (
    .srca       (op_q.srca),
    .srcb       (op_q.srcb),
    .alucontrol (op_q.alucontrol),
    .aluout     (rsp_aluout),
    .zero       (rsp_zero)
  );

endmodule
